sha1_sequencer: RTL and testbench
=================================

SHA1_SEQUENCER -- requirements
Module: sha1_sequencer

Interface
REQ-001 clk  in  1  rising-edge clock, sole clock domain.
REQ-002 rst_n  in  1  asynchronous active-low reset.
REQ-003 start  in  1  request one digest sequence; sampled only in IDLE.
REQ-004 adv  in  1  datapath consumed current bit; beat advances only when high.
REQ-005 init_bit  in  1  bit returned by constant source for (init_sel, step).
REQ-006 round_bit  in  1  bit returned by constant source for (round_sel, step).
REQ-007 init_sel  out  5  one-hot H-word select to constant source (bit w = H<w>).
REQ-008 round_sel  out  4  one-hot K select (bit3 = K0..19, bit2 = K20..39, bit1 = K40..59, bit0 = K60..79).
REQ-009 step  out  5  bit index within current 32-bit word, LSB first.
REQ-010 phase  out  2  0 IDLE, 1 INIT, 2 ROUND, 3 FINAL.
REQ-011 round  out  7  current round 0..79 (held 0 outside ROUND).
REQ-012 h_bit  out  1  init_bit gated to INIT/FINAL, else 0.
REQ-013 k_bit  out  1  round_bit gated to ROUND, else 0.
REQ-014 bit_valid  out  1  high in INIT, ROUND and FINAL.
REQ-015 busy  out  1  high whenever phase != IDLE.
REQ-016 done  out  1  one-cycle pulse at sequence completion.

Function
REQ-017 States IDLE -> INIT -> ROUND -> FINAL -> IDLE; phase output encodes state directly.
REQ-018 IDLE + start -> INIT at next edge with step=0, word=0; start outside IDLE ignored.
REQ-019 A beat completes at an edge where bit_valid and adv are both high; no advance otherwise (all outputs held).
REQ-020 step increments per beat, wraps 31 -> 0; wrap advances word (INIT/FINAL, 0..4) or round (ROUND, 0..79).
REQ-021 INIT: init_sel = 1<<word, round_sel = 0; after word 4 step 31 -> ROUND, round=0, step=0.
REQ-022 ROUND: round_sel from round/20 per REQ-008, init_sel = 0; after round 79 step 31 -> FINAL word 0 (or IDLE, REQ-029).
REQ-023 FINAL: identical select behaviour to INIT; after word 4 step 31 -> IDLE.
REQ-024 Selects, step, phase, round are registered; h_bit/k_bit are combinational from inputs, zero-latency.
REQ-025 done high exactly the one cycle after the final beat; busy low in that cycle; start in that cycle is accepted.
REQ-026 adv low for any duration freezes sequence without bit loss or duplication; adv in IDLE ignored.

Reset
REQ-027 rst_n low asynchronously forces IDLE: init_sel=0, round_sel=0, step=0, round=0, phase=0, busy=0, done=0, bit_valid=0, h_bit=0, k_bit=0.
REQ-028 Reset mid-sequence abandons it; no done pulse; next start restarts from INIT word 0 step 0.

Configuration
REQ-029 Macro SHA1_SEQ_FINAL_ADD_EN defined: FINAL phase present (160 beats re-emitting H0..H4 for digest addition); undefined: ROUND round 79 step 31 goes directly to IDLE, phase never 3, FINAL logic absent.

Verification
REQ-030 Reset, start pulse, adv=1 constant, source model: beats 1..160 init_sel 00001..10000, h_bit reproduces 67452301, efcdab89, 98badcfe, 10325476, c3d2e1f0 LSB first.
REQ-031 Same run: round_sel 1000 for rounds 0..19, 0100, 0010, 0001 at 20/40/60; k_bit word per round equals 5a827999/6ed9eba1/8f1bbcdc/ca62c1d6.
REQ-032 Same run with macro: done one cycle after beat 2880, busy low; without macro done after beat 2720.
REQ-033 adv random 50% duty: collected h_bit/k_bit streams identical to REQ-030/031; done only after all beats.
REQ-034 start pulsed repeatedly during busy -> no restart, single done; start in done cycle -> new INIT begins next cycle.
REQ-035 rst_n low at round 37 step 12 -> all outputs zero immediately, no done; subsequent start gives full clean sequence.

Source files
------------

// File: rtl/sha1_sequencer.sv
// sha1_sequencer: bit-serial SHA-1 constant sequencer.
// Steps a datapath through H0..H4 (INIT), K for rounds 0..79 (ROUND) and,
// optionally, H0..H4 again for the final digest addition (FINAL). Every 32-bit
// word is presented LSB first, one bit per beat; a beat completes on a clock
// edge where bit_valid and adv are both high.
//
// Build option: define SHA1_SEQ_FINAL_ADD_EN to include the FINAL phase.
// Without it the sequence ends after round 79 and phase never reads 3.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start                begin a sequence (accepted only when idle)
//   adv                  datapath consumed the current bit
//   init_bit, round_bit  bits returned by the external constant source
//   init_sel, round_sel  one-hot H-word / K-group selects to the source
//   step                 bit index within the current word
//   phase                0 idle, 1 init, 2 round, 3 final
//   round                current round (0 outside ROUND)
//   h_bit, k_bit         source bits gated to their phases
//   bit_valid, busy      sequence active
//   done                 one-cycle pulse after the last beat
module sha1_sequencer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       adv,
    input  logic       init_bit,
    input  logic       round_bit,
    output logic [4:0] init_sel,
    output logic [3:0] round_sel,
    output logic [4:0] step,
    output logic [1:0] phase,
    output logic [6:0] round,
    output logic       h_bit,
    output logic       k_bit,
    output logic       bit_valid,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StInit  = 2'd1,
        StRound = 2'd2,
        StFinal = 2'd3
    } state_e;

    state_e     state_q, state_d;
    logic [4:0] step_q, step_d;
    logic [2:0] word_q, word_d;
    logic [6:0] round_q, round_d;
    logic [4:0] init_sel_q, init_sel_d;
    logic [3:0] round_sel_q, round_sel_d;
    logic       done_q, done_d;
    logic       beat;

    // K group select for a given round: K0..19 on bit 3 down to K60..79 on bit 0.
    function automatic logic [3:0] k_group(input logic [6:0] r);
        if (r < 7'd20)      k_group = 4'b1000;
        else if (r < 7'd40) k_group = 4'b0100;
        else if (r < 7'd60) k_group = 4'b0010;
        else                k_group = 4'b0001;
    endfunction

    assign beat = (state_q != StIdle) && adv;

    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        word_d      = word_q;
        round_d     = round_q;
        init_sel_d  = init_sel_q;
        round_sel_d = round_sel_q;
        done_d      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d     = StInit;
                    step_d      = 5'd0;
                    word_d      = 3'd0;
                    round_d     = 7'd0;
                    init_sel_d  = 5'b00001;
                    round_sel_d = 4'b0000;
                end
            end

`ifdef SHA1_SEQ_FINAL_ADD_EN
            StInit, StFinal: begin
`else
            StInit: begin
`endif
                if (beat) begin
                    step_d = step_q + 5'd1;
                    if (step_q == 5'd31) begin
                        if (word_q == 3'd4) begin
                            word_d     = 3'd0;
                            init_sel_d = 5'b00000;
`ifdef SHA1_SEQ_FINAL_ADD_EN
                            if (state_q == StFinal) begin
                                state_d = StIdle;
                                done_d  = 1'b1;
                            end else
`endif
                            begin
                                state_d     = StRound;
                                round_d     = 7'd0;
                                round_sel_d = k_group(7'd0);
                            end
                        end else begin
                            word_d     = word_q + 3'd1;
                            init_sel_d = init_sel_q << 1;
                        end
                    end
                end
            end

            StRound: begin
                if (beat) begin
                    step_d = step_q + 5'd1;
                    if (step_q == 5'd31) begin
                        if (round_q == 7'd79) begin
                            round_d     = 7'd0;
                            round_sel_d = 4'b0000;
`ifdef SHA1_SEQ_FINAL_ADD_EN
                            state_d     = StFinal;
                            word_d      = 3'd0;
                            init_sel_d  = 5'b00001;
`else
                            state_d     = StIdle;
                            done_d      = 1'b1;
`endif
                        end else begin
                            round_d     = round_q + 7'd1;
                            round_sel_d = k_group(round_q + 7'd1);
                        end
                    end
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            step_q      <= 5'd0;
            word_q      <= 3'd0;
            round_q     <= 7'd0;
            init_sel_q  <= 5'd0;
            round_sel_q <= 4'd0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            word_q      <= word_d;
            round_q     <= round_d;
            init_sel_q  <= init_sel_d;
            round_sel_q <= round_sel_d;
            done_q      <= done_d;
        end
    end

    assign init_sel  = init_sel_q;
    assign round_sel = round_sel_q;
    assign step      = step_q;
    assign phase     = state_q;
    assign round     = round_q;
    assign bit_valid = (state_q != StIdle);
    assign busy      = (state_q != StIdle);
    assign done      = done_q;
    // Source bits pass straight through, masked to the phase that owns them.
    assign h_bit     = init_bit & ((state_q == StInit) || (state_q == StFinal));
    assign k_bit     = round_bit & (state_q == StRound);

endmodule

// File: tb/tb_sha1_sequencer.sv
// Self-checking bench for sha1_sequencer: a directed table walk through the
// phase boundaries, then full sequences driven by a model constant source.
module tb_sha1_sequencer;

`ifdef SHA1_SEQ_FINAL_ADD_EN
    localparam int EXP_BEATS = 2880;
`else
    localparam int EXP_BEATS = 2720;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       adv = 1'b0;
    logic       init_bit, round_bit;
    logic [4:0] init_sel;
    logic [3:0] round_sel;
    logic [4:0] step;
    logic [1:0] phase;
    logic [6:0] round;
    logic       h_bit, k_bit, bit_valid, busy, done;

    logic       src_mode = 1'b0;
    logic       tb_ib = 1'b0;
    logic       tb_rb = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    sha1_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .adv       (adv),
        .init_bit  (init_bit),
        .round_bit (round_bit),
        .init_sel  (init_sel),
        .round_sel (round_sel),
        .step      (step),
        .phase     (phase),
        .round     (round),
        .h_bit     (h_bit),
        .k_bit     (k_bit),
        .bit_valid (bit_valid),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] h_word(input int i);
        case (i)
            0:       h_word = 32'h67452301;
            1:       h_word = 32'hefcdab89;
            2:       h_word = 32'h98badcfe;
            3:       h_word = 32'h10325476;
            default: h_word = 32'hc3d2e1f0;
        endcase
    endfunction

    function automatic logic [31:0] k_word(input int i);
        case (i)
            0:       k_word = 32'h5a827999;
            1:       k_word = 32'h6ed9eba1;
            2:       k_word = 32'h8f1bbcdc;
            default: k_word = 32'hca62c1d6;
        endcase
    endfunction

    function automatic int oh5(input logic [4:0] v);
        case (v)
            5'b00001: oh5 = 0;
            5'b00010: oh5 = 1;
            5'b00100: oh5 = 2;
            5'b01000: oh5 = 3;
            5'b10000: oh5 = 4;
            default:  oh5 = -1;
        endcase
    endfunction

    function automatic int oh4(input logic [3:0] v);
        case (v)
            4'b1000: oh4 = 0;
            4'b0100: oh4 = 1;
            4'b0010: oh4 = 2;
            4'b0001: oh4 = 3;
            default: oh4 = -1;
        endcase
    endfunction

    // Model constant source: answers whatever the DUT selects.
    logic [31:0] src_h, src_k;
    int          src_hi, src_ki;
    always_comb begin
        src_hi    = oh5(init_sel);
        src_ki    = oh4(round_sel);
        src_h     = (src_hi < 0) ? 32'h0 : h_word(src_hi);
        src_k     = (src_ki < 0) ? 32'h0 : k_word(src_ki);
        init_bit  = src_mode ? src_h[step] : tb_ib;
        round_bit = src_mode ? src_k[step] : tb_rb;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        int unsigned n;
        logic        ib;
        logic        rb;
        logic [1:0]  ph;
        logic [4:0]  isel;
        logic [3:0]  rsel;
        logic [4:0]  st;
        logic [6:0]  rnd;
        logic        h;
        logic        k;
        logic        dn;
        logic        bsy;
    } vec_t;

    vec_t tbl[$];

    // Start a sequence and drive it to completion, rebuilding each word from
    // the bit stream and checking done timing.
    task automatic run_seq(input bit rnd, input bit pulse, input string tag);
        logic [31:0] hi[5];
        logic [31:0] hf[5];
        logic [31:0] kw[80];
        logic [3:0]  rs[80];
        int          beats;
        int          bad_sel;
        int          idx;
        bit          got_done;
        beats    = 0;
        bad_sel  = 0;
        got_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            hi[i] = 32'h0;
            hf[i] = 32'h0;
        end
        for (int i = 0; i < 80; i++) begin
            kw[i] = 32'h0;
            rs[i] = 4'h0;
        end
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int cyc = 0; cyc < 20000; cyc++) begin
            adv = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (pulse) start = (beats < EXP_BEATS - 4) ? 1'($urandom_range(0, 1)) : 1'b0;
            #3;
            if (done) begin
                got_done = 1'b1;
                break;
            end
            if (beats == EXP_BEATS) break;
            if (bit_valid && adv) begin
                case (phase)
                    2'd1: begin
                        idx = oh5(init_sel);
                        if (idx < 0 || round_sel != 4'h0) bad_sel++;
                        else hi[idx][step] = h_bit;
                    end
                    2'd2: begin
                        if (init_sel != 5'h0 || round > 7'd79) bad_sel++;
                        else begin
                            kw[round][step] = k_bit;
                            rs[round]       = round_sel;
                        end
                    end
                    default: begin
                        idx = oh5(init_sel);
                        if (idx < 0 || round_sel != 4'h0) bad_sel++;
                        else hf[idx][step] = h_bit;
                    end
                endcase
                beats++;
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        chk({tag, " done_seen"}, 64'(got_done), 64'd1);
        chk({tag, " beats_before_done"}, 64'(beats), 64'(EXP_BEATS));
        chk({tag, " busy_in_done"}, 64'(busy), 64'd0);
        chk({tag, " select_errors"}, 64'(bad_sel), 64'd0);
        for (int w = 0; w < 5; w++) chk($sformatf("%s h_init%0d", tag, w), 64'(hi[w]),
                                        64'(h_word(w)));
`ifdef SHA1_SEQ_FINAL_ADD_EN
        for (int w = 0; w < 5; w++) chk($sformatf("%s h_final%0d", tag, w), 64'(hf[w]),
                                        64'(h_word(w)));
`endif
        for (int r = 0; r < 80; r++) begin
            chk($sformatf("%s k_round%0d", tag, r), 64'(kw[r]), 64'(k_word(r / 20)));
            chk($sformatf("%s rsel_round%0d", tag, r), 64'(rs[r]), 64'(4'b1000 >> (r / 20)));
        end
    endtask

    initial begin
        int dn_cnt;
        bit found;

        // Reset: outputs held at zero whatever the inputs do.
        for (int v = 0; v < 16; v++) begin
            {start, adv, tb_ib, tb_rb} = 4'(v);
            #2;
            chk($sformatf("reset_outputs_v%0d", v),
                64'({init_sel, round_sel, step, phase, round, busy, done, bit_valid,
                     h_bit, k_bit}), 64'd0);
        end
        start = 1'b0;
        adv   = 1'b1;
        tb_ib = 1'b1;
        tb_rb = 1'b1;
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_ignores_adv", 64'({phase, step, busy, h_bit, k_bit}), 64'd0);
        adv = 1'b0;

        // Directed walk across the phase boundaries; n = beats before the row.
        tbl.push_back('{0,   1, 1, 2'd1, 5'b00001, 4'b0000, 5'd0,  7'd0,  1, 0, 0, 1});
        tbl.push_back('{31,  0, 1, 2'd1, 5'b00001, 4'b0000, 5'd31, 7'd0,  0, 0, 0, 1});
        tbl.push_back('{1,   1, 0, 2'd1, 5'b00010, 4'b0000, 5'd0,  7'd0,  1, 0, 0, 1});
        tbl.push_back('{128, 1, 1, 2'd2, 5'b00000, 4'b1000, 5'd0,  7'd0,  0, 1, 0, 1});
        tbl.push_back('{640, 0, 1, 2'd2, 5'b00000, 4'b0100, 5'd0,  7'd20, 0, 1, 0, 1});
        tbl.push_back('{5,   1, 0, 2'd2, 5'b00000, 4'b0100, 5'd5,  7'd20, 0, 0, 0, 1});
        tbl.push_back('{635, 1, 1, 2'd2, 5'b00000, 4'b0010, 5'd0,  7'd40, 0, 1, 0, 1});
        tbl.push_back('{640, 1, 1, 2'd2, 5'b00000, 4'b0001, 5'd0,  7'd60, 0, 1, 0, 1});
        tbl.push_back('{639, 0, 1, 2'd2, 5'b00000, 4'b0001, 5'd31, 7'd79, 0, 1, 0, 1});
`ifdef SHA1_SEQ_FINAL_ADD_EN
        tbl.push_back('{1,   1, 1, 2'd3, 5'b00001, 4'b0000, 5'd0,  7'd0,  1, 0, 0, 1});
        tbl.push_back('{160, 1, 1, 2'd0, 5'b00000, 4'b0000, 5'd0,  7'd0,  0, 0, 1, 0});
`else
        tbl.push_back('{1,   1, 1, 2'd0, 5'b00000, 4'b0000, 5'd0,  7'd0,  0, 0, 1, 0});
`endif
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        foreach (tbl[i]) begin
            if (tbl[i].n > 0) begin
                adv = 1'b1;
                repeat (tbl[i].n) @(posedge clk);
                #1 adv = 1'b0;
            end
            tb_ib = tbl[i].ib;
            tb_rb = tbl[i].rb;
            #1;
            chk($sformatf("walk_row%0d", i),
                64'({phase, init_sel, round_sel, step, round, h_bit, k_bit, done, busy,
                     bit_valid}),
                64'({tbl[i].ph, tbl[i].isel, tbl[i].rsel, tbl[i].st, tbl[i].rnd, tbl[i].h,
                     tbl[i].k, tbl[i].dn, tbl[i].bsy, tbl[i].bsy}));
        end
        @(posedge clk);
        #1;
        chk("done_single_cycle", 64'(done), 64'd0);

        // Full sequence, adv constant high, then start in the done cycle.
        src_mode = 1'b1;
        run_seq(1'b0, 1'b0, "steady");
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("restart_in_done_cycle", 64'({phase, step, init_sel, busy}),
            64'({2'd1, 5'd0, 5'b00001, 1'b1}));
        rst_n = 1'b0;
        #2 rst_n = 1'b1;

        // adv toggling at random must not drop or duplicate bits.
        run_seq(1'b1, 1'b0, "random_adv");
        @(posedge clk);
        #1;

        // start pulsed while busy: no restart, exactly one done.
        run_seq(1'b0, 1'b1, "start_spam");
        dn_cnt = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (done) dn_cnt++;
        end
        chk("no_restart_after_done", 64'({phase, busy}), 64'd0);
        chk("extra_done_pulses", 64'(dn_cnt), 64'd0);

        // Reset at round 37 step 12 abandons the sequence.
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        adv   = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 5000; c++) begin
            @(posedge clk);
            #1;
            if (phase == 2'd2 && round == 7'd37 && step == 5'd12) begin
                found = 1'b1;
                break;
            end
        end
        chk("reached_round37_step12", 64'(found), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs",
            64'({init_sel, round_sel, step, phase, round, busy, done, bit_valid, h_bit, k_bit}),
            64'd0);
        dn_cnt = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done) dn_cnt++;
        end
        chk("no_done_after_reset", 64'(dn_cnt), 64'd0);
        adv = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_seq(1'b0, 1'b0, "after_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
